// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic datapath: opcode encoding and requester ID width.
package logic_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ID_W = 1;

    typedef logic [OP_W-1:0] logic_op_t;

    localparam logic_op_t OP_AND  = 3'b000;
    localparam logic_op_t OP_OR   = 3'b001;
    localparam logic_op_t OP_XOR  = 3'b010;
    localparam logic_op_t OP_NAND = 3'b011;
    localparam logic_op_t OP_NOR  = 3'b100;
    localparam logic_op_t OP_XNOR = 3'b101;
    localparam logic_op_t OP_NOTA = 3'b110;
    localparam logic_op_t OP_NOTB = 3'b111;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Issue-side request channels and writeback-side result channel of the shared logic unit.
interface logic_unit_arbiter_if
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic_op_t        req_op0;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic_op_t        req_op1;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [ID_W-1:0]  out_id;
    logic_op_t        out_op;
    logic [CNT_W-1:0] done_count;

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_op, done_count
    );

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, out_ready,
        output req_ready, out_valid, out_data, out_id, out_op, done_count
    );
endinterface

// File: rtl/logic_op_core.sv
// Purely combinational 8-way bitwise function select; reusable by any execution unit.
module logic_op_core
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic_op_t        op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_NOTA: y_o = ~a_i;
            OP_NOTB: y_o = ~b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic datapath between two issue ports, with a single-slot
// registered result stage and a count of results consumed by writeback.
module logic_unit_arbiter
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]  out_id_q,    out_id_d;
    logic_op_t        out_op_q,    out_op_d;
    logic [CNT_W-1:0] done_q,      done_d;
    logic             prio_q,      prio_d;

    logic             can_accept;
    logic             accept;
    logic [1:0]       grant;
    logic [1:0]       ready;
    logic [ID_W-1:0]  acc_id;
    logic_op_t        sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] core_y;

    // Grant: a lone requester always wins; on contention prio picks the winner.
    always_comb begin
        grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
        can_accept = ~out_valid_q | bus.out_ready;
        ready      = grant & {2{can_accept & ~rst}};
        accept     = |ready;
        acc_id     = ready[1];
        sel_op     = acc_id[0] ? bus.req_op1 : bus.req_op0;
        sel_a      = acc_id[0] ? bus.req_a1  : bus.req_a0;
        sel_b      = acc_id[0] ? bus.req_b1  : bus.req_b0;
    end

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op_i (sel_op),
        .a_i  (sel_a),
        .b_i  (sel_b),
        .y_o  (core_y)
    );

    // Next state: drain clears the slot unless a same-cycle accept refills it.
    always_comb begin
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_op_d    = out_op_q;
        done_d      = done_q;
        prio_d      = prio_q;
        if (out_valid_q && bus.out_ready) begin
            done_d = done_q + CNT_W'(1);
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = core_y;
            out_id_d    = acc_id;
            out_op_d    = sel_op;
            prio_d      = ~acc_id[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_op_q    <= OP_AND;
            done_q      <= '0;
            prio_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_op_q    <= out_op_d;
            done_q      <= done_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_op     = out_op_q;
    assign bus.done_count = done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: per-cycle vector table plus hand sequences for
// backpressure, mid-stream reset and counter wrap (counter narrowed to 4 bits).
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        ordy;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic [31:0] e_data;
        logic        e_id;
        logic [2:0]  e_op;
        logic [3:0]  e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic_unit_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] valid,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic ordy, input logic [1:0] e_rdy, input logic e_ov,
                                input logic [31:0] e_data, input logic e_id, input logic [2:0] e_op,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.valid = valid; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data; v.e_id = e_id;
        v.e_op = e_op; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge.
    task automatic apply(input string tag, input vec_t v);
        bus.req_valid = v.valid;
        bus.req_op0   = v.op0;
        bus.req_a0    = v.a0;
        bus.req_b0    = v.b0;
        bus.req_op1   = v.op1;
        bus.req_a1    = v.a1;
        bus.req_b1    = v.b1;
        bus.out_ready = v.ordy;
        @(negedge clk);
        chk({tag, " req_ready"},  32'(bus.req_ready),  32'(v.e_rdy));
        chk({tag, " out_valid"},  32'(bus.out_valid),  32'(v.e_ov));
        chk({tag, " out_data"},   bus.out_data,        v.e_data);
        chk({tag, " out_id"},     32'(bus.out_id),     32'(v.e_id));
        chk({tag, " out_op"},     32'(bus.out_op),     32'(v.e_op));
        chk({tag, " done_count"}, 32'(bus.done_count), 32'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [16];
    vec_t v;

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = mk(2'b01, 3'd0, 32'h33333333, 32'hCCCCCCCC, 3'd0, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 32'h00000000, 1'b0, 3'd0, 4'd0);
        tbl[1]  = mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'h00000000, 1'b0, 3'd0, 4'd0);
        tbl[2]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd0, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b0, 32'h00000000, 1'b0, 3'd0, 4'd1);
        tbl[3]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd1, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'hF0F0F0F0, 1'b1, 3'd0, 4'd1);
        tbl[4]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd2, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b1, 3'd1, 4'd2);
        tbl[5]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd3, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'h0F0F0F0F, 1'b1, 3'd2, 4'd3);
        tbl[6]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd4, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'h0F0F0F0F, 1'b1, 3'd3, 4'd4);
        tbl[7]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd5, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'h00000000, 1'b1, 3'd4, 4'd5);
        tbl[8]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd6, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'hF0F0F0F0, 1'b1, 3'd5, 4'd6);
        tbl[9]  = mk(2'b10, 3'd0, 32'h0, 32'h0, 3'd7, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b1, 2'b10, 1'b1, 32'h00000000, 1'b1, 3'd6, 4'd7);
        tbl[10] = mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'h0F0F0F0F, 1'b1, 3'd7, 4'd8);
        tbl[11] = mk(2'b11, 3'd1, 32'h55555555, 32'hAAAAAAAA, 3'd2, 32'h00000000, 32'hFF00FF00, 1'b1, 2'b01, 1'b0, 32'h0F0F0F0F, 1'b1, 3'd7, 4'd9);
        tbl[12] = mk(2'b11, 3'd1, 32'h55555555, 32'hAAAAAAAA, 3'd2, 32'h00000000, 32'hFF00FF00, 1'b1, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b0, 3'd1, 4'd9);
        tbl[13] = mk(2'b11, 3'd1, 32'h55555555, 32'hAAAAAAAA, 3'd2, 32'h00000000, 32'hFF00FF00, 1'b1, 2'b01, 1'b1, 32'hFF00FF00, 1'b1, 3'd2, 4'd10);
        tbl[14] = mk(2'b11, 3'd1, 32'h55555555, 32'hAAAAAAAA, 3'd2, 32'h00000000, 32'hFF00FF00, 1'b1, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b0, 3'd1, 4'd11);
        tbl[15] = mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'hFF00FF00, 1'b1, 3'd2, 4'd12);

        // Two reset cycles with both requesters asserting; nothing may be granted.
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_op0   = 3'd0; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1   = 3'd0; bus.req_a1 = '0; bus.req_b1 = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Backpressure: result held for 3 stalled cycles, then drain and accept together.
        apply("bp0", mk(2'b01, 3'd5, 32'h12345678, 32'h12345678, 3'd0, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 32'hFF00FF00, 1'b1, 3'd2, 4'd13));
        for (int i = 1; i <= 3; i++) begin
            apply($sformatf("bp%0d", i), mk(2'b11, 3'd5, 32'h12345678, 32'h12345678, 3'd3, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, 3'd5, 4'd13));
        end
        apply("bp4", mk(2'b11, 3'd5, 32'h12345678, 32'h12345678, 3'd3, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 2'b10, 1'b1, 32'hFFFFFFFF, 1'b0, 3'd5, 4'd13));
        apply("bp5", mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'hF0F0FFFF, 1'b1, 3'd3, 4'd14));

        // Mid-stream reset: pending result and the request in the reset cycle are dropped.
        apply("rs0", mk(2'b01, 3'd1, 32'h1, 32'h2, 3'd0, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 32'hF0F0FFFF, 1'b1, 3'd3, 4'd15));
        rst = 1'b1;
        apply("rs1", mk(2'b01, 3'd0, 32'hF, 32'h6, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'h00000003, 1'b0, 3'd1, 4'd15));
        rst = 1'b0;
        apply("rs2", mk(2'b11, 3'd0, 32'hF, 32'h6, 3'd1, 32'h1, 32'h2, 1'b1, 2'b01, 1'b0, 32'h00000000, 1'b0, 3'd0, 4'd0));
        apply("rs3", mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'h00000006, 1'b0, 3'd0, 4'd0));

        // Counter wrap: 17 consumed results on a 4-bit counter leave it at 1.
        rst = 1'b1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            v = mk(2'b01, 3'd2, 32'(k), 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b01,
                   (k > 0), (k > 0) ? 32'(k - 1) : 32'h0, 1'b0,
                   (k > 0) ? 3'd2 : 3'd0, (k > 0) ? 4'(k - 1) : 4'd0);
            apply($sformatf("wrap%0d", k), v);
        end
        apply("wrap17", mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 32'd16, 1'b0, 3'd2, 4'd0));
        apply("wrap18", mk(2'b00, 3'd0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 32'd16, 1'b0, 3'd2, 4'd1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
